// File: rtl/timer_pkg.sv
// Shared types and constants for the timer comparator sequencer.
// State encoding, register map addresses and CTRL bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PERIOD = 2'd1;
  localparam logic [1:0] A_ACK    = 2'd2;

  localparam int B_RUN     = 0;
  localparam int B_ONESHOT = 1;
  localparam int B_IRQEN   = 2;

endpackage

// File: rtl/timer_presc.sv
// Sample-tick prescaler: counts 0..PRESCALE-1 while EN, else held at 0.
// Ports: CK, nRES (async low), EN in; TICK out (one CK at terminal count).
module timer_presc #(
  parameter int PRESCALE = 384,
  parameter int PW       = 9
) (
  input  logic CK,
  input  logic nRES,
  input  logic EN,
  output logic TICK
);

  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge CK or negedge nRES) begin
    if (!nRES) begin
      cnt <= '0;
    end else if (!EN || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Timer comparator sequencer: register map, FSM, ACC, JKCK strobe, IRQ.
// Ports: CK, nRES, PIN_DB_IN[7:0], PIN_AB[1:0], nWR in;
//        ACC[7:0], JKCK, nIRQ, BUSY out.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE = 384,
  parameter int PW       = 9
) (
  input  logic       CK,
  input  logic       nRES,
  input  logic [7:0] PIN_DB_IN,
  input  logic [1:0] PIN_AB,
  input  logic       nWR,
  output logic [7:0] ACC,
  output logic       JKCK,
  output logic       nIRQ,
  output logic       BUSY
);

  state_t     state;
  logic       nwr_d;
  logic [2:0] ctrl;
  logic [7:0] period;

  logic       wr;
  logic       ctrl_wr;
  logic       per_wr;
  logic       ack_wr;
  logic [2:0] ctrl_n;
  logic       en;
  logic       tick;
  logic       match;
  logic       irq_set;

  always_comb begin
    wr      = !nWR && nwr_d;
    ctrl_wr = wr && (PIN_AB == A_CTRL);
    per_wr  = wr && (PIN_AB == A_PERIOD);
    ack_wr  = wr && (PIN_AB == A_ACK);
    // CTRL as it will be after this edge; a same-edge RUN clear
    // therefore suppresses the tick and any match.
    ctrl_n  = ctrl_wr ? PIN_DB_IN[2:0] : ctrl;
    en      = (state == COUNT) && ctrl_n[B_RUN];
    match   = tick && (ACC == period);
    irq_set = match && ctrl_n[B_IRQEN];
  end

  timer_presc #(
    .PRESCALE (PRESCALE),
    .PW       (PW)
  ) u_presc (
    .CK   (CK),
    .nRES (nRES),
    .EN   (en),
    .TICK (tick)
  );

  always_ff @(posedge CK or negedge nRES) begin
    if (!nRES) begin
      state  <= IDLE;
      nwr_d  <= 1'b1;
      ctrl   <= '0;
      period <= '0;
      ACC    <= '0;
      JKCK   <= 1'b0;
      nIRQ   <= 1'b1;
    end else begin
      nwr_d <= nWR;
      JKCK  <= 1'b0;
      ctrl  <= ctrl_n;
      if (per_wr) begin
        period <= PIN_DB_IN;
      end
      // set wins over a same-edge ACK
      nIRQ <= !(irq_set || (!nIRQ && !ack_wr));
      unique case (state)
        IDLE, HOLD: begin
          ACC <= '0;
          if (ctrl_n[B_RUN]) begin
            state <= COUNT;
          end
        end
        COUNT: begin
          if (!ctrl_n[B_RUN]) begin
            state <= IDLE;
            ACC   <= '0;
          end else if (match) begin
            ACC  <= '0;
            JKCK <= 1'b1;
            if (ctrl_n[B_ONESHOT]) begin
              ctrl[B_RUN] <= 1'b0;
              state       <= HOLD;
            end
          end else if (tick) begin
            ACC <= ACC + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          ACC   <= '0;
        end
      endcase
    end
  end

  assign BUSY = (state == COUNT);

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with PRESCALE=4.
// Table vectors, directed corner sequences and randomized runs.
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int PS = 4;

  logic       CK = 1'b0;
  logic       nRES = 1'b1;
  logic       nWR = 1'b1;
  logic [7:0] PIN_DB_IN = '0;
  logic [1:0] PIN_AB = '0;
  logic [7:0] ACC;
  logic       JKCK;
  logic       nIRQ;
  logic       BUSY;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CK = ~CK;

  timer_ctrl #(
    .PRESCALE (PS),
    .PW       (3)
  ) dut (
    .CK        (CK),
    .nRES      (nRES),
    .PIN_DB_IN (PIN_DB_IN),
    .PIN_AB    (PIN_AB),
    .nWR       (nWR),
    .ACC       (ACC),
    .JKCK      (JKCK),
    .nIRQ      (nIRQ),
    .BUSY      (BUSY)
  );

  typedef struct {
    logic [7:0] per;
    logic [7:0] ctrl;
    int         t;
    logic [7:0] acc;
    logic       jk;
    logic       nirq;
    logic       busy;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // one write strobe; the write lands on the second posedge
  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    @(posedge CK);
    #1;
    PIN_AB = a;
    PIN_DB_IN = d;
    nWR = 1'b0;
    @(posedge CK);
    #1;
    nWR = 1'b1;
  endtask

  // stop, clear IRQ, program; returns 1 after the RUN edge (t=0)
  task automatic start_run(input logic [7:0] p, input logic [7:0] c);
    wr_reg(A_CTRL, 8'h00);
    wr_reg(A_ACK, 8'h00);
    wr_reg(A_PERIOD, p);
    wr_reg(A_CTRL, c);
  endtask

  initial begin
    int P, os, ie, per, n, L;
    logic [7:0] c;
    bit done;

    tbl[0] = '{8'd2, 8'h05, 12, 8'd0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{8'd2, 8'h01, 12, 8'd0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{8'd2, 8'h05, 11, 8'd2, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{8'd0, 8'h03, 4,  8'd0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'd0, 8'h07, 9,  8'd0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'd5, 8'h01, 17, 8'd4, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{8'd3, 8'h00, 10, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'd1, 8'h06, 8,  8'd0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{8'd7, 8'hFD, 32, 8'd0, 1'b1, 1'b0, 1'b1};

    #2 nRES = 1'b0;
    #1;
    chk("rst_acc", ACC, 0);
    chk("rst_jkck", JKCK, 0);
    chk("rst_nirq", nIRQ, 1);
    chk("rst_busy", BUSY, 0);
    repeat (2) @(negedge CK);
    nRES = 1'b1;
    repeat (3) @(negedge CK);
    chk("idle_busy", BUSY, 0);

    // table vectors
    foreach (tbl[i]) begin
      start_run(tbl[i].per, tbl[i].ctrl);
      repeat (tbl[i].t + 1) @(negedge CK);
      chk($sformatf("tbl%0d_acc", i), ACC, tbl[i].acc);
      chk($sformatf("tbl%0d_jkck", i), JKCK, tbl[i].jk);
      chk($sformatf("tbl%0d_nirq", i), nIRQ, tbl[i].nirq);
      chk($sformatf("tbl%0d_busy", i), BUSY, tbl[i].busy);
    end

    // periodic pulses with IRQ, then ACK
    start_run(8'd2, 8'h05);
    for (int t = 0; t <= 36; t++) begin
      @(negedge CK);
      chk("per_jkck", JKCK, (t > 0 && t % 12 == 0));
      chk("per_nirq", nIRQ, (t >= 12) ? 0 : 1);
    end
    wr_reg(A_ACK, 8'h5A);
    @(negedge CK);
    chk("ack_nirq", nIRQ, 1);

    // one-shot, then re-arm from HOLD
    start_run(8'd0, 8'h03);
    for (int t = 0; t <= 104; t++) begin
      @(negedge CK);
      chk("os_jkck", JKCK, (t == 4));
      chk("os_busy", BUSY, (t < 4));
    end
    wr_reg(A_CTRL, 8'h01);
    for (int t = 0; t <= 12; t++) begin
      @(negedge CK);
      chk("rearm_jkck", JKCK, (t > 0 && t % 4 == 0));
      chk("rearm_busy", BUSY, 1);
    end

    // RUN cleared on a tick edge that would match
    start_run(8'd0, 8'h01);
    repeat (7) @(negedge CK);
    wr_reg(A_CTRL, 8'h00);
    @(negedge CK);
    chk("clr_jkck", JKCK, 0);
    chk("clr_busy", BUSY, 0);
    chk("clr_acc", ACC, 0);

    // ACK on the match edge: set wins
    start_run(8'd2, 8'h05);
    repeat (11) @(negedge CK);
    wr_reg(A_ACK, 8'h00);
    @(negedge CK);
    chk("ackm_jkck", JKCK, 1);
    chk("ackm_nirq", nIRQ, 0);
    wr_reg(A_ACK, 8'h00);
    @(negedge CK);
    chk("ack2_nirq", nIRQ, 1);

    // PERIOD lowered below ACC: full wrap before match
    start_run(8'd10, 8'h01);
    repeat (21) @(negedge CK);
    chk("wrap_acc5", ACC, 5);
    wr_reg(A_PERIOD, 8'd1);
    for (int t = 22; t <= 1032; t++) begin
      @(negedge CK);
      n = t / PS;
      chk("wrap_acc", ACC, (n >= 258) ? 0 : n % 256);
      chk("wrap_jkck", JKCK, (t == 1032));
    end

    // long ACK strobe: one clear, later set survives
    start_run(8'd0, 8'h05);
    repeat (6) @(negedge CK);
    chk("long_pend", nIRQ, 0);
    PIN_AB = A_ACK;
    nWR = 1'b0;
    for (int t = 6; t <= 25; t++) begin
      @(negedge CK);
      chk("long_nirq", nIRQ, (t < 8) ? 1 : 0);
    end
    nWR = 1'b1;

    // randomized runs against arithmetic model
    for (int tr = 0; tr < 8; tr++) begin
      P = $urandom_range(0, 7);
      os = $urandom_range(0, 1);
      ie = $urandom_range(0, 1);
      c = 8'(ie * 4 + os * 2 + 1);
      per = (P + 1) * PS;
      L = per * 3 + 3;
      start_run(8'(P), c);
      for (int t = 0; t <= L; t++) begin
        @(negedge CK);
        n = t / PS;
        done = (n >= P + 1);
        chk("rnd_acc", ACC, (os == 1 && done) ? 0 : n % (P + 1));
        chk("rnd_jkck", JKCK,
            (t > 0 && t % PS == 0 && n % (P + 1) == 0 &&
             (os == 0 || n == P + 1)));
        chk("rnd_nirq", nIRQ, (ie == 1 && done) ? 0 : 1);
        chk("rnd_busy", BUSY, (os == 1 && done) ? 0 : 1);
      end
    end

    // async reset mid-count
    start_run(8'd10, 8'h01);
    repeat (13) @(negedge CK);
    chk("mid_acc3", ACC, 3);
    nRES = 1'b0;
    #1;
    chk("mid_rst_acc", ACC, 0);
    chk("mid_rst_jkck", JKCK, 0);
    chk("mid_rst_nirq", nIRQ, 1);
    chk("mid_rst_busy", BUSY, 0);
    repeat (2) @(negedge CK);
    nRES = 1'b1;
    repeat (10) @(negedge CK);
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_acc", ACC, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
